// File: rtl/chrono_run_controller_pkg.sv
// Shared constants for the chronometer run controller: FSM state codes and timing defaults.
package chrono_run_controller_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_RUNNING    = 3'd1;
    localparam logic [2:0] ST_PAUSED     = 3'd2;
    localparam logic [2:0] ST_LAP_RUN    = 3'd3;
    localparam logic [2:0] ST_LAP_PAUSED = 3'd4;

    // 10 ms at 50 MHz, both for button settling and the 100 Hz centisecond tick
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int TICK_100HZ_PERIOD       = 500000;

    function automatic logic is_counting(input logic [2:0] st);
        return (st == ST_RUNNING) || (st == ST_LAP_RUN);
    endfunction

    function automatic logic is_frozen(input logic [2:0] st);
        return (st == ST_LAP_RUN) || (st == ST_LAP_PAUSED);
    endfunction

endpackage

// File: rtl/chrono_run_controller_debouncer.sv
// One pushbutton: 2-FF synchronizer, stability counter and single-cycle press pulse.
module button_debouncer
    import chrono_run_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int DEB_CNT_W       = 20
) (
    input  logic qzt_clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 sync_p0;
    logic                 sync_p1;
    logic                 level;
    logic                 level_d;
    logic [DEB_CNT_W-1:0] cnt;

    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            // Count only while the synchronized input disagrees with the accepted level
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/chrono_run_controller.sv
// Run/stop/lap controller for the 4-digit BCD chronometer: debounces buttons, sequences
// the counter chain and holds the lap-freeze value shown on the display.
module chrono_run_controller
    import chrono_run_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int DEB_CNT_W       = 20
) (
    input  logic        qzt_clk,
    input  logic        reset,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_reset,
    input  logic [15:0] live_time,
    output logic        count_run,
    output logic        count_clear,
    output logic [15:0] disp_time,
    output logic        lap_frozen,
    output logic [2:0]  state_code
);

    logic        ss_press;
    logic        lap_press;
    logic        rst_press;
    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic        lap_capture;
    logic [15:0] lap_reg;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEB_CNT_W       (DEB_CNT_W)
    ) u_deb_start_stop (
        .qzt_clk (qzt_clk),
        .reset   (reset),
        .btn     (btn_start_stop),
        .press   (ss_press)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEB_CNT_W       (DEB_CNT_W)
    ) u_deb_lap (
        .qzt_clk (qzt_clk),
        .reset   (reset),
        .btn     (btn_lap),
        .press   (lap_press)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEB_CNT_W       (DEB_CNT_W)
    ) u_deb_reset (
        .qzt_clk (qzt_clk),
        .reset   (reset),
        .btn     (btn_reset),
        .press   (rst_press)
    );

    // Reset beats start/stop beats lap; lower-priority presses in the same cycle are dropped
    always_comb begin
        state_nxt   = state;
        lap_capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst_press)     state_nxt = ST_IDLE;
                else if (ss_press) state_nxt = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (rst_press)      state_nxt = ST_IDLE;
                else if (ss_press)  state_nxt = ST_PAUSED;
                else if (lap_press) begin
                    state_nxt   = ST_LAP_RUN;
                    lap_capture = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (rst_press)     state_nxt = ST_IDLE;
                else if (ss_press) state_nxt = ST_RUNNING;
            end
            ST_LAP_RUN: begin
                if (rst_press)      state_nxt = ST_IDLE;
                else if (ss_press)  state_nxt = ST_LAP_PAUSED;
                else if (lap_press) state_nxt = ST_RUNNING;
            end
            ST_LAP_PAUSED: begin
                if (rst_press)      state_nxt = ST_IDLE;
                else if (ss_press)  state_nxt = ST_LAP_RUN;
                else if (lap_press) state_nxt = ST_PAUSED;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            count_run   <= 1'b0;
            count_clear <= 1'b0;
            lap_frozen  <= 1'b0;
            lap_reg     <= '0;
            disp_time   <= '0;
        end else begin
            state       <= state_nxt;
            count_run   <= is_counting(state_nxt);
            lap_frozen  <= is_frozen(state_nxt);
            count_clear <= rst_press;
            if (rst_press) begin
                lap_reg <= '0;
            end else if (lap_capture) begin
                lap_reg <= live_time;
            end
            // Display follows the registered freeze flag, so it lags a freeze change by one cycle
            disp_time <= lap_frozen ? lap_reg : live_time;
        end
    end

    assign state_code = state;

endmodule

// File: tb/tb_chrono_run_controller.sv
// Bench for chrono_run_controller: table-driven button steps, hand corner sequences and
// randomized buttons/live_time checked every cycle against a behavioural model.
module tb_chrono_run_controller;

    localparam int D = 4;

    logic        qzt_clk;
    logic        reset;
    logic        btn_start_stop;
    logic        btn_lap;
    logic        btn_reset;
    logic [15:0] live_time;
    logic        count_run;
    logic        count_clear;
    logic [15:0] disp_time;
    logic        lap_frozen;
    logic [2:0]  state_code;

    chrono_run_controller #(
        .DEBOUNCE_CYCLES (D),
        .DEB_CNT_W       (20)
    ) dut (
        .qzt_clk        (qzt_clk),
        .reset          (reset),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_reset      (btn_reset),
        .live_time      (live_time),
        .count_run      (count_run),
        .count_clear    (count_clear),
        .disp_time      (disp_time),
        .lap_frozen     (lap_frozen),
        .state_code     (state_code)
    );

    initial qzt_clk = 1'b0;
    always #5 qzt_clk = ~qzt_clk;

    int total;
    int bad;

    // Behavioural model: buttons are index 0=reset, 1=start_stop, 2=lap
    logic [2:0]  m_state;
    logic        m_run;
    logic        m_clear;
    logic        m_frozen;
    logic [15:0] m_lap;
    logic [15:0] m_disp;
    logic        m_acc [3];
    int          m_runlen [3];
    int          m_act [3];
    int          edge_n;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        m_state  = 3'd0;
        m_run    = 1'b0;
        m_clear  = 1'b0;
        m_frozen = 1'b0;
        m_lap    = 16'h0000;
        m_disp   = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            m_acc[i]    = 1'b0;
            m_runlen[i] = 0;
            m_act[i]    = -1;
        end
    endtask

    function automatic logic raw_of(input int i);
        if (i == 0) return btn_reset;
        if (i == 1) return btn_start_stop;
        return btn_lap;
    endfunction

    // A raw level must be seen on D consecutive edges to be accepted; an accepted
    // rise acts on the FSM 4 edges after its D-th sample (D+3 edges to the pulse).
    task automatic model_edge();
        logic        p [3];
        logic        r;
        logic [15:0] disp_next;
        edge_n++;
        for (int i = 0; i < 3; i++) begin
            p[i] = (m_act[i] == edge_n);
            if (p[i]) m_act[i] = -1;
        end
        for (int i = 0; i < 3; i++) begin
            r = raw_of(i);
            if (r == m_acc[i]) begin
                m_runlen[i] = 0;
            end else begin
                m_runlen[i]++;
                if (m_runlen[i] == D) begin
                    m_acc[i]    = r;
                    m_runlen[i] = 0;
                    if (r) m_act[i] = edge_n + 4;
                end
            end
        end
        disp_next = m_frozen ? m_lap : live_time;
        m_clear   = 1'b0;
        if (p[0]) begin
            m_state = 3'd0;
            m_clear = 1'b1;
            m_lap   = 16'h0000;
        end else if (p[1]) begin
            case (m_state)
                3'd0:    m_state = 3'd1;
                3'd1:    m_state = 3'd2;
                3'd2:    m_state = 3'd1;
                3'd3:    m_state = 3'd4;
                default: m_state = 3'd3;
            endcase
        end else if (p[2]) begin
            case (m_state)
                3'd1: begin
                    m_state = 3'd3;
                    m_lap   = live_time;
                end
                3'd3:    m_state = 3'd1;
                3'd4:    m_state = 3'd2;
                default: m_state = m_state;
            endcase
        end
        m_run    = (m_state == 3'd1) || (m_state == 3'd3);
        m_frozen = (m_state == 3'd3) || (m_state == 3'd4);
        m_disp   = disp_next;
    endtask

    task automatic check_outputs();
        chk("state_code",  16'(state_code),  16'(m_state));
        chk("count_run",   16'(count_run),   16'(m_run));
        chk("count_clear", 16'(count_clear), 16'(m_clear));
        chk("lap_frozen",  16'(lap_frozen),  16'(m_frozen));
        chk("disp_time",   disp_time,        m_disp);
    endtask

    task automatic tick();
        @(posedge qzt_clk);
        if (reset) begin
            edge_n++;
            model_reset();
        end else begin
            model_edge();
        end
        @(negedge qzt_clk);
        check_outputs();
    endtask

    task automatic set_btns(input logic [2:0] b);
        btn_reset      = b[2];
        btn_start_stop = b[1];
        btn_lap        = b[0];
    endtask

    task automatic press(input logic [2:0] b);
        set_btns(b);
        repeat (10) tick();
        set_btns(3'b000);
        repeat (8) tick();
    endtask

    typedef struct {
        logic [2:0]  btn;
        logic [15:0] live;
        logic [2:0]  st;
        logic        run;
        logic        frz;
        logic [15:0] disp;
    } vec_t;

    vec_t        tbl [16];
    int          clr_cnt;
    int          first_lap;
    int          sel;
    logic [2:0]  b;

    initial begin
        total = 0;
        bad   = 0;
        edge_n = 0;
        reset = 1'b1;
        set_btns(3'b000);
        live_time = 16'h0000;
        model_reset();

        // btn = {reset, start_stop, lap}; sequence begins in RUNNING
        tbl[0]  = '{3'b001, 16'h0342, 3'd3, 1'b1, 1'b1, 16'h0342};
        tbl[1]  = '{3'b000, 16'h0517, 3'd3, 1'b1, 1'b1, 16'h0342};
        tbl[2]  = '{3'b010, 16'h0517, 3'd4, 1'b0, 1'b1, 16'h0342};
        tbl[3]  = '{3'b010, 16'h0517, 3'd3, 1'b1, 1'b1, 16'h0342};
        tbl[4]  = '{3'b001, 16'h0517, 3'd1, 1'b1, 1'b0, 16'h0517};
        tbl[5]  = '{3'b010, 16'h0520, 3'd2, 1'b0, 1'b0, 16'h0520};
        tbl[6]  = '{3'b001, 16'h0521, 3'd2, 1'b0, 1'b0, 16'h0521};
        tbl[7]  = '{3'b010, 16'h0522, 3'd1, 1'b1, 1'b0, 16'h0522};
        tbl[8]  = '{3'b001, 16'h0600, 3'd3, 1'b1, 1'b1, 16'h0600};
        tbl[9]  = '{3'b010, 16'h0601, 3'd4, 1'b0, 1'b1, 16'h0600};
        tbl[10] = '{3'b001, 16'h0602, 3'd2, 1'b0, 1'b0, 16'h0602};
        tbl[11] = '{3'b010, 16'h0603, 3'd1, 1'b1, 1'b0, 16'h0603};
        tbl[12] = '{3'b110, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000};
        tbl[13] = '{3'b001, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000};
        tbl[14] = '{3'b010, 16'h0010, 3'd1, 1'b1, 1'b0, 16'h0010};
        tbl[15] = '{3'b100, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000};

        #1;
        chk("reset_state",       16'(state_code),  16'h0000);
        chk("reset_count_run",   16'(count_run),   16'h0000);
        chk("reset_count_clear", 16'(count_clear), 16'h0000);
        chk("reset_lap_frozen",  16'(lap_frozen),  16'h0000);
        chk("reset_disp_time",   disp_time,        16'h0000);
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();

        // Start latency: count_run rises exactly 8 edges after the raw rise
        set_btns(3'b010);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 7) chk("start_latency_before", 16'(count_run), 16'h0000);
            if (k == 8) begin
                chk("start_latency_at", 16'(count_run), 16'h0001);
                chk("start_state", 16'(state_code), 16'h0001);
            end
        end
        set_btns(3'b000);
        repeat (8) tick();
        chk("start_single_pulse", 16'(state_code), 16'h0001);

        // Lap button bouncing before settling high
        first_lap = -1;
        for (int k = 1; k <= 16; k++) begin
            btn_lap = (k <= 4) ? ((k % 2) == 1) : 1'b1;
            tick();
            if (state_code == 3'd3 && first_lap < 0) first_lap = k;
        end
        btn_lap = 1'b0;
        repeat (8) tick();
        chk("bounce_lap_entry_edge", 16'(first_lap), 16'd12);
        chk("bounce_lap_state", 16'(state_code), 16'h0003);
        press(3'b001);
        chk("bounce_unfreeze", 16'(state_code), 16'h0001);

        // Display tracks live_time with one cycle of latency when not frozen
        live_time = 16'h1234;
        tick();
        chk("disp_latency", disp_time, 16'h1234);

        for (int i = 0; i < 16; i++) begin
            live_time = tbl[i].live;
            set_btns(tbl[i].btn);
            clr_cnt = 0;
            repeat (10) begin
                tick();
                if (count_clear) clr_cnt++;
            end
            set_btns(3'b000);
            repeat (8) begin
                tick();
                if (count_clear) clr_cnt++;
            end
            chk($sformatf("tbl%0d_state", i), 16'(state_code), 16'(tbl[i].st));
            chk($sformatf("tbl%0d_run", i),   16'(count_run),  16'(tbl[i].run));
            chk($sformatf("tbl%0d_frz", i),   16'(lap_frozen), 16'(tbl[i].frz));
            chk($sformatf("tbl%0d_disp", i),  disp_time,       tbl[i].disp);
            chk($sformatf("tbl%0d_clear_pulses", i), 16'(clr_cnt), tbl[i].btn[2] ? 16'd1 : 16'd0);
        end

        // Asynchronous port reset while in LAP_PAUSED
        live_time = 16'h0777;
        press(3'b010);
        press(3'b001);
        press(3'b010);
        chk("pre_async_state", 16'(state_code), 16'h0004);
        #2 reset = 1'b1;
        #1;
        chk("async_state",       16'(state_code),  16'h0000);
        chk("async_count_run",   16'(count_run),   16'h0000);
        chk("async_lap_frozen",  16'(lap_frozen),  16'h0000);
        chk("async_count_clear", 16'(count_clear), 16'h0000);
        chk("async_disp_time",   disp_time,        16'h0000);
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();

        // Randomized buttons, bounces and live_time against the model
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 8)       b = 3'b100;
            else if (sel < 12) b = 3'b110;
            else if (sel < 55) b = 3'b010;
            else if (sel < 95) b = 3'b001;
            else               b = 3'b011;
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    set_btns(b);
                    live_time = 16'($urandom);
                    tick();
                    set_btns(3'b000);
                    live_time = 16'($urandom);
                    tick();
                end
            end
            set_btns(b);
            repeat ($urandom_range(5, 12)) begin
                live_time = 16'($urandom);
                tick();
            end
            set_btns(3'b000);
            repeat ($urandom_range(6, 12)) begin
                live_time = 16'($urandom);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
